// File: rtl/fp_div_lane_seq_pkg.sv
// Shared types and constants for the FP divide lane sequencer.
//   div_seq_state_t : sequencer FSM states (IDLE, ISSUE, WAIT, RESP)
//   FP_QNAN, FP_ONE : IEEE-754 single-precision constants
//   fp_is_nan()     : single-precision NaN test
package pkg_opengpu;

  localparam int DATA_WIDTH = 32;

  localparam logic [31:0] FP_QNAN = 32'h7FC00000;
  localparam logic [31:0] FP_ONE  = 32'h3F800000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } div_seq_state_t;

  function automatic logic fp_is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

endpackage

// File: rtl/fp_div_lane_seq_lane_pick_first.sv
// Combinational find-first-set: returns the index of the lowest set bit of
// `bits` and whether any bit is set. idx is 0 when no bit is set.
// Ports:
//   bits : N-bit lane vector
//   idx  : index of the lowest set bit
//   any  : at least one bit set
module lane_pick_first #(
  parameter int N     = 8,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     bits,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Scan from the top down so the lowest set bit wins.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (bits[i]) begin
        idx = IDX_W'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fp_div_lane_seq.sv
// Issue-side sequencer for the shared multi-cycle FP divider. Accepts one
// warp-wide divide request, feeds the active lanes one at a time (lowest lane
// first) to the divider, gathers the quotients and returns one response.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; valid, once raised, holds with stable payload until that edge.
// Divider side: div_start is a single-cycle pulse, never raised while
// div_busy is high; div_valid is only honoured in WAIT.
//
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   req_valid/req_ready           : request handshake
//   req_mask/req_a/req_b/req_tag  : active lanes, dividends, divisors, tag
//   resp_valid/resp_ready         : response handshake
//   resp_data/resp_mask/resp_tag  : quotients (inactive lanes 0), mask, tag
//   div_start/div_a/div_b         : divider issue
//   div_result/div_valid/div_busy : divider return and status
//   busy                          : high whenever the FSM is not IDLE
//   dbg_state                     : current FSM state
//
// Build option OPENGPU_DIV_BYPASS_ONE_EN: a lane whose divisor is exactly
// +1.0 bypasses the divider (result = dividend, or canonical qNaN for a NaN
// dividend), resolved in a single ISSUE cycle.
module fp_div_lane_seq
  import pkg_opengpu::*;
#(
  parameter int NUM_LANES = 8,
  parameter int TAG_W     = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            req_valid,
  output logic                            req_ready,
  input  logic [NUM_LANES-1:0]            req_mask,
  input  logic [NUM_LANES*DATA_WIDTH-1:0] req_a,
  input  logic [NUM_LANES*DATA_WIDTH-1:0] req_b,
  input  logic [TAG_W-1:0]                req_tag,
  output logic                            resp_valid,
  input  logic                            resp_ready,
  output logic [NUM_LANES*DATA_WIDTH-1:0] resp_data,
  output logic [NUM_LANES-1:0]            resp_mask,
  output logic [TAG_W-1:0]                resp_tag,
  output logic                            div_start,
  output logic [DATA_WIDTH-1:0]           div_a,
  output logic [DATA_WIDTH-1:0]           div_b,
  input  logic [DATA_WIDTH-1:0]           div_result,
  input  logic                            div_valid,
  input  logic                            div_busy,
  output logic                            busy,
  output div_seq_state_t                  dbg_state
);

  localparam int LW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  div_seq_state_t state, state_next;

  logic [NUM_LANES*DATA_WIDTH-1:0] a_q, b_q, data_q;
  logic [NUM_LANES-1:0]            mask_q, pending;
  logic [TAG_W-1:0]                tag_q;

  logic [LW-1:0]        lane_idx;
  logic                 pending_any;
  logic [NUM_LANES-1:0] lane_bit, pending_rest;
  logic                 bypass_hit;

  lane_pick_first #(.N(NUM_LANES), .IDX_W(LW)) u_pick (
    .bits (pending),
    .idx  (lane_idx),
    .any  (pending_any)
  );

  assign lane_bit     = {{(NUM_LANES-1){1'b0}}, 1'b1} << lane_idx;
  assign pending_rest = pending & ~lane_bit;

  // Operands always come from the registered copy, so they are never X.
  assign div_a = a_q[int'(lane_idx)*DATA_WIDTH +: DATA_WIDTH];
  assign div_b = b_q[int'(lane_idx)*DATA_WIDTH +: DATA_WIDTH];

`ifdef OPENGPU_DIV_BYPASS_ONE_EN
  logic [DATA_WIDTH-1:0] bypass_val;
  assign bypass_hit = (div_b == FP_ONE);
  assign bypass_val = fp_is_nan(div_a) ? FP_QNAN : div_a;
`else
  assign bypass_hit = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next state and divider start
  always_comb begin
    state_next = state;
    div_start  = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) state_next = (req_mask == '0) ? RESP : ISSUE;
      end
      ISSUE: begin
        if (!pending_any) begin
          state_next = RESP;
        end else if (bypass_hit) begin
          state_next = (pending_rest != '0) ? ISSUE : RESP;
        end else if (!div_busy) begin
          div_start  = 1'b1;
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (div_valid) state_next = (pending_rest != '0) ? ISSUE : RESP;
      end
      RESP: begin
        if (resp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Request capture and per-lane result collection
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      data_q  <= '0;
      mask_q  <= '0;
      tag_q   <= '0;
      pending <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            a_q     <= req_a;
            b_q     <= req_b;
            mask_q  <= req_mask;
            tag_q   <= req_tag;
            pending <= req_mask;
            data_q  <= '0;
          end
        end
`ifdef OPENGPU_DIV_BYPASS_ONE_EN
        ISSUE: begin
          if (pending_any && bypass_hit) begin
            data_q[int'(lane_idx)*DATA_WIDTH +: DATA_WIDTH] <= bypass_val;
            pending[lane_idx] <= 1'b0;
          end
        end
`endif
        WAIT: begin
          if (div_valid) begin
            data_q[int'(lane_idx)*DATA_WIDTH +: DATA_WIDTH] <= div_result;
            pending[lane_idx] <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign req_ready  = (state == IDLE) && !rst;
  assign resp_valid = (state == RESP);
  assign resp_data  = data_q;
  assign resp_mask  = mask_q;
  assign resp_tag   = tag_q;
  assign busy       = (state != IDLE);
  assign dbg_state  = state;

endmodule

// File: tb/tb_fp_div_lane_seq.sv
module tb_fp_div_lane_seq;
  import pkg_opengpu::*;

  localparam int NL = 8;
  localparam int TW = 4;
  localparam int DW = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic                 req_valid = 1'b0, req_ready;
  logic [NL-1:0]        req_mask = '0;
  logic [NL*DW-1:0]     req_a = '0, req_b = '0;
  logic [TW-1:0]        req_tag = '0;
  logic                 resp_valid, resp_ready = 1'b0;
  logic [NL*DW-1:0]     resp_data;
  logic [NL-1:0]        resp_mask;
  logic [TW-1:0]        resp_tag;
  logic                 div_start;
  logic [DW-1:0]        div_a, div_b, div_result;
  logic                 div_valid, div_busy;
  logic                 busy;
  div_seq_state_t       dbg_state;

  fp_div_lane_seq #(.NUM_LANES(NL), .TAG_W(TW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_mask(req_mask),
    .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_mask(resp_mask), .resp_tag(resp_tag),
    .div_start(div_start), .div_a(div_a), .div_b(div_b),
    .div_result(div_result), .div_valid(div_valid), .div_busy(div_busy),
    .busy(busy), .dbg_state(dbg_state)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- reference arithmetic ----------------
  function automatic logic is_special(input logic [31:0] x);
    return (x[30:23] == 8'h00) || (x[30:23] == 8'hFF);
  endfunction

  function automatic real sp2r(input logic [31:0] x);
    logic [63:0] d;
    int e;
    e = int'(x[30:23]) - 127 + 1023;
    d = {x[31], e[10:0], x[22:0], 29'b0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2sp(input real r);
    logic [63:0] d;
    int e;
    d = $realtobits(r);
    e = int'(d[62:52]) - 1023 + 127;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  // Behaviour of the divider stand-in: specials give qNaN after 3 cycles,
  // normal operands give the (truncated) quotient after 7 cycles.
  function automatic int div_lat(input logic [31:0] a, input logic [31:0] b);
    return (is_special(a) || is_special(b)) ? 3 : 7;
  endfunction

  function automatic logic [31:0] div_fn(input logic [31:0] a, input logic [31:0] b);
    if (is_special(a) || is_special(b)) return FP_QNAN;
    return r2sp(sp2r(a) / sp2r(b));
  endfunction

  function automatic logic is_bypass(input logic [31:0] b);
`ifdef OPENGPU_DIV_BYPASS_ONE_EN
    return b == FP_ONE;
`else
    return (b != b);
`endif
  endfunction

  function automatic logic [31:0] bypass_result(input logic [31:0] a);
    return ((a[30:23] == 8'hFF) && (a[22:0] != 0)) ? FP_QNAN : a;
  endfunction

  // ---------------- divider model (responder) ----------------
  int          busy_hold = 0;
  bit          inject = 1'b0;
  bit          dv_active = 1'b0;
  int          dv_cnt = 0;
  logic [31:0] dv_res = '0;
  logic [63:0] got_q[$];
  int          got_cyc_q[$];

  initial begin
    div_busy = 1'b0; div_valid = 1'b0; div_result = '0;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        dv_active = 1'b0; div_valid = 1'b0; div_busy = 1'b0; busy_hold = 0;
      end else begin
        div_valid = 1'b0;
        if (dv_active) begin
          dv_cnt--;
          if (dv_cnt == 0) begin
            div_valid = 1'b1; div_result = dv_res; dv_active = 1'b0;
          end
        end
        if (inject) begin
          div_valid = 1'b1; div_result = 32'hDEADBEEF; inject = 1'b0;
        end
        if (busy_hold > 0) begin
          div_busy = 1'b1; busy_hold--;
        end else begin
          div_busy = dv_active;
        end
        #1;
        if (div_start) begin
          check("start_while_busy", div_busy, 1'b0);
          got_q.push_back({div_a, div_b});
          got_cyc_q.push_back(cyc);
          dv_active = 1'b1;
          dv_cnt    = div_lat(div_a, div_b);
          dv_res    = div_fn(div_a, div_b);
        end
      end
    end
  end

  // ---------------- scoreboard model ----------------
  logic [63:0] exp_q[$];
  int          exp_cyc_q[$];

  task automatic model(input logic [NL-1:0] mask, input logic [NL*DW-1:0] a,
                       input logic [NL*DW-1:0] b, input int busy_extra,
                       output logic [NL*DW-1:0] exp_data, output int exp_cycle);
    int t;
    bit first;
    logic [31:0] ai, bi;
    exp_q.delete(); exp_cyc_q.delete();
    exp_data = '0;
    t = 1;
    first = 1'b1;
    for (int i = 0; i < NL; i++) begin
      if (mask[i]) begin
        ai = a[i*DW +: DW];
        bi = b[i*DW +: DW];
        if (is_bypass(bi)) begin
          exp_data[i*DW +: DW] = bypass_result(ai);
          t += 1;
        end else begin
          if (first) t += busy_extra;
          first = 1'b0;
          exp_q.push_back({ai, bi});
          exp_cyc_q.push_back(t);
          exp_data[i*DW +: DW] = div_fn(ai, bi);
          t += div_lat(ai, bi) + 1;
        end
      end
    end
    exp_cycle = t;
  endtask

  // ---------------- driver ----------------
  task automatic do_req(input string name, input logic [NL-1:0] mask,
                        input logic [NL*DW-1:0] a, input logic [NL*DW-1:0] b,
                        input logic [TW-1:0] tag, input int busy_extra,
                        input int ready_delay, input int exp_cycle_in);
    logic [NL*DW-1:0] exp_data;
    int exp_cycle, t0, n;
    bit rr_bad, unstable;
    model(mask, a, b, busy_extra, exp_data, exp_cycle);
    if (exp_cycle_in >= 0) exp_cycle = exp_cycle_in;
    got_q.delete(); got_cyc_q.delete();
    @(negedge clk);
    req_mask = mask; req_a = a; req_b = b; req_tag = tag; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 100) begin @(negedge clk); n++; end
    t0 = cyc;
    busy_hold = (busy_extra > 0) ? busy_extra + 1 : 0;
    @(negedge clk);
    req_valid = 1'b0;
    rr_bad = 1'b0;
    n = 0;
    while (!resp_valid && n < 1000) begin
      if (req_ready) rr_bad = 1'b1;
      @(negedge clk);
      n++;
    end
    check({name, "_resp_seen"}, resp_valid, 1'b1);
    check({name, "_resp_cycle"}, cyc - t0, exp_cycle);
    check({name, "_data"}, resp_data, exp_data);
    check({name, "_mask"}, resp_mask, mask);
    check({name, "_tag"}, resp_tag, tag);
    check({name, "_req_ready_low"}, rr_bad, 1'b0);
    unstable = 1'b0;
    for (int k = 0; k < ready_delay; k++) begin
      @(negedge clk);
      if (resp_valid !== 1'b1 || resp_data !== exp_data || resp_mask !== mask ||
          resp_tag !== tag || req_ready !== 1'b0)
        unstable = 1'b1;
    end
    if (ready_delay > 0) check({name, "_resp_stable"}, unstable, 1'b0);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check({name, "_back_idle"}, {resp_valid, req_ready, busy}, 3'b010);
    check({name, "_start_count"}, got_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
      check($sformatf("%s_start%0d_operands", name, k), got_q[k], exp_q[k]);
      check($sformatf("%s_start%0d_cycle", name, k), got_cyc_q[k] - t0, exp_cyc_q[k]);
    end
  endtask

  function automatic logic [31:0] rand_normal();
    logic [31:0] v;
    v = $urandom;
    v[30:23] = 8'($urandom_range(120, 134));
    return v;
  endfunction

  typedef struct {
    string            name;
    logic [NL-1:0]    mask;
    logic [NL*DW-1:0] a;
    logic [NL*DW-1:0] b;
    logic [TW-1:0]    tag;
    int               busy_extra;
    int               ready_delay;
    int               exp_cycle;
    logic [31:0]      exp_lane0;
  } vec_t;

  vec_t vecs[$];

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic [NL*DW-1:0] base_a, base_b, a, b;
    vec_t v;
    int n;

    for (int i = 0; i < NL; i++) begin
      base_a[i*DW +: DW] = 32'h40C00000 + (i << 18);
      base_b[i*DW +: DW] = 32'h40000000 + (i << 17);
    end

    v = '{"single", 8'h01, base_a, base_b, 4'h1, 0, 0, 9, 32'h40400000};
    vecs.push_back(v);
    v = '{"four", 8'hA5, base_a, base_b, 4'h9, 0, 1, 33, 32'h40400000};
    vecs.push_back(v);
    v = '{"empty", 8'h00, base_a, base_b, 4'h3, 0, 0, 1, 32'h00000000};
    vecs.push_back(v);
    v = '{"busy_hold", 8'h01, base_a, base_b, 4'h5, 5, 4, 14, 32'h40400000};
    vecs.push_back(v);
    b = base_b; b[31:0] = 32'h00000000;
    v = '{"special", 8'h81, base_a, b, 4'hC, 0, 0, 13, FP_QNAN};
    vecs.push_back(v);
    a = base_a; a[31:0] = 32'hC1200000;
    b = base_b; b[31:0] = FP_ONE;
`ifdef OPENGPU_DIV_BYPASS_ONE_EN
    v = '{"one_div", 8'h03, a, b, 4'h7, 0, 0, 10, 32'hC1200000};
`else
    v = '{"one_div", 8'h03, a, b, 4'h7, 0, 0, 17, 32'hC1200000};
`endif
    vecs.push_back(v);

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_outputs", {req_ready, resp_valid, div_start, busy}, 4'b0000);
    check("rst_data", {resp_data, resp_mask, resp_tag, div_a, div_b}, '0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_after_rst", {req_ready, busy, dbg_state}, {1'b1, 1'b0, IDLE});

    // Directed table
    foreach (vecs[i]) begin
      do_req(vecs[i].name, vecs[i].mask, vecs[i].a, vecs[i].b, vecs[i].tag,
             vecs[i].busy_extra, vecs[i].ready_delay, vecs[i].exp_cycle);
      check({vecs[i].name, "_lane0"}, resp_data[31:0], vecs[i].exp_lane0);
    end

    // Reset during WAIT of lane 2, then a late divider result
    got_q.delete(); got_cyc_q.delete();
    @(negedge clk);
    req_mask = 8'h07; req_a = base_a; req_b = base_b; req_tag = 4'hA; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (got_q.size() < 3 && n < 200) begin @(negedge clk); n++; end
    check("rst_mid_third_start", got_q.size(), 3);
    @(negedge clk);
    @(negedge clk);
    check("rst_mid_in_wait", dbg_state, WAIT);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_outputs", {req_ready, resp_valid, div_start, busy}, 4'b0000);
    check("rst_mid_data", {resp_data, resp_mask, resp_tag, div_a, div_b}, '0);
    rst = 1'b0;
    @(negedge clk);
    inject = 1'b1;
    n = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (resp_valid || busy || !req_ready) n++;
    end
    check("rst_mid_late_valid_ignored", n, 0);
    do_req("after_rst", 8'h07, base_a, base_b, 4'h2, 0, 0, 25);

    // Randomized requests against the model
    for (int r = 0; r < 12; r++) begin
      logic [NL-1:0] m;
      m = 8'($urandom_range(0, 255));
      for (int i = 0; i < NL; i++) begin
        a[i*DW +: DW] = rand_normal();
        b[i*DW +: DW] = rand_normal();
        case ($urandom_range(0, 9))
          0: b[i*DW +: DW] = 32'h00000000;
          1: b[i*DW +: DW] = 32'h7F800000;
          2: b[i*DW +: DW] = FP_ONE;
          3: begin b[i*DW +: DW] = FP_ONE; a[i*DW +: DW] = 32'h7FA00001; end
          default: ;
        endcase
      end
      do_req($sformatf("rand%0d", r), m, a, b, 4'($urandom_range(0, 15)), 0,
             $urandom_range(0, 3), -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
